// File: rtl/stack_control_unit.sv
// Stack-control decoder: decides return-address push (JAL) or pop (stop bit),
// computes the next stack pointer and flags boundary violations. Everything is
// combinational except the sticky error flag.
module stack_control_unit #(
  parameter int unsigned     SP_W    = 32,
  parameter logic [SP_W-1:0] SP_BASE = SP_W'(32'h0000_0000),
  parameter logic [SP_W-1:0] SP_MAX  = SP_W'(32'h0000_00FF)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      instr_type,
  input  logic [4:0]      opcode,
  input  logic            stop_bit,
  input  logic [SP_W-1:0] sp,
  input  logic            commit,
  output logic            push,
  output logic            pop,
  output logic [SP_W-1:0] next_sp,
  output logic            overflow,
  output logic            underflow,
  output logic            stack_err
);

  typedef enum logic [1:0] {
    CLS_R = 2'b00,
    CLS_I = 2'b01,
    CLS_J = 2'b10,
    CLS_S = 2'b11
  } instr_class_e;

  localparam logic [4:0] OP_JAL = 5'b00001;

  logic push_req;
  logic pop_req;
  logic stack_err_q;
  logic stack_err_d;

  // Decode push/pop requests, guard the stack boundaries, derive next SP.
  always_comb begin
    push_req  = 1'b0;
    pop_req   = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    next_sp   = sp;

    // Push has priority: the stop bit on a JAL is ignored.
    push_req  = (instr_type == CLS_J) && (opcode == OP_JAL);
    pop_req   = stop_bit && !push_req;

    overflow  = push_req && (sp == SP_MAX);
    underflow = pop_req && (sp == SP_BASE);

    push      = push_req && !overflow;
    pop       = pop_req && !underflow;

    if (push) begin
      next_sp = sp + SP_W'(1);
    end else if (pop) begin
      next_sp = sp - SP_W'(1);
    end
  end

  // Sticky error: set when a boundary violation is committed, cleared only by reset.
  always_comb begin
    stack_err_d = stack_err_q;
    if (commit && (overflow || underflow)) begin
      stack_err_d = 1'b1;
    end
  end

  // Error flag register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stack_err_q <= 1'b0;
    end else begin
      stack_err_q <= stack_err_d;
    end
  end

  assign stack_err = stack_err_q;

endmodule

// File: tb/tb_stack_control_unit.sv
// Testbench for stack_control_unit: directed vector table, hand-written
// sticky-error/reset sequences, and randomized stimulus against a depth model.
module tb_stack_control_unit;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] MAXV = 32'h0000_00FF;

  logic        clk;
  logic        reset_n;
  logic [1:0]  instr_type;
  logic [4:0]  opcode;
  logic        stop_bit;
  logic [31:0] sp;
  logic        commit;
  logic        push;
  logic        pop;
  logic [31:0] next_sp;
  logic        overflow;
  logic        underflow;
  logic        stack_err;

  int n_vec;
  int n_err;

  stack_control_unit #(
    .SP_W   (32),
    .SP_BASE(BASE),
    .SP_MAX (MAXV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .instr_type(instr_type),
    .opcode    (opcode),
    .stop_bit  (stop_bit),
    .sp        (sp),
    .commit    (commit),
    .push      (push),
    .pop       (pop),
    .next_sp   (next_sp),
    .overflow  (overflow),
    .underflow (underflow),
    .stack_err (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  it;
    logic [4:0]  op;
    logic        sb;
    logic [31:0] sp;
    logic        e_push;
    logic        e_pop;
    logic [31:0] e_nsp;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] it, input logic [4:0] op,
                              input logic sb, input logic [31:0] s,
                              input logic ep, input logic epo,
                              input logic [31:0] ensp,
                              input logic eo, input logic eu);
    vec_t v;
    v.it = it; v.op = op; v.sb = sb; v.sp = s;
    v.e_push = ep; v.e_pop = epo; v.e_nsp = ensp; v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  task automatic check1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_comb(input string tag, input logic ep, input logic epo,
                            input logic [31:0] ensp, input logic eo, input logic eu);
    check1 ({tag, ".push"}, push, ep);
    check1 ({tag, ".pop"}, pop, epo);
    check32({tag, ".next_sp"}, next_sp, ensp);
    check1 ({tag, ".overflow"}, overflow, eo);
    check1 ({tag, ".underflow"}, underflow, eu);
  endtask

  task automatic drive(input logic [1:0] it, input logic [4:0] op,
                       input logic sb, input logic [31:0] s, input logic c);
    instr_type = it;
    opcode     = op;
    stop_bit   = sb;
    sp         = s;
    commit     = c;
  endtask

  // Reference model in terms of stack depth: only a JAL pushes, and only while
  // the stack has room; a stop bit pops if something is on the stack.
  logic        m_push, m_pop, m_ovf, m_unf;
  logic [31:0] m_nsp;
  task automatic model(input logic [1:0] it, input logic [4:0] op,
                       input logic sb, input logic [31:0] s);
    int unsigned depth;
    int unsigned capacity;
    bit          wants_push;
    bit          wants_pop;
    depth      = s - BASE;
    capacity   = MAXV - BASE;
    wants_push = (it == 2'd2) && (op == 5'd1);
    wants_pop  = (sb == 1'b1) && !wants_push;
    m_ovf      = wants_push && (depth == capacity);
    m_unf      = wants_pop && (depth == 0);
    m_push     = wants_push && (depth < capacity);
    m_pop      = wants_pop && (depth > 0);
    if (m_push)     depth = depth + 1;
    else if (m_pop) depth = depth - 1;
    m_nsp      = BASE + depth;
  endtask

  logic err_m;

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    drive(2'b00, 5'd0, 1'b0, 32'd8, 1'b0);
    #2;
    check1("reset.stack_err", stack_err, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table
    tbl.push_back(mk(2'b00, 5'b00000, 0, 32'd8, 0, 0, 32'd8, 0, 0)); // R AND
    tbl.push_back(mk(2'b00, 5'b00001, 0, 32'd8, 0, 0, 32'd8, 0, 0)); // R ADD
    tbl.push_back(mk(2'b00, 5'b00010, 0, 32'd8, 0, 0, 32'd8, 0, 0)); // R SUB
    tbl.push_back(mk(2'b01, 5'b00000, 0, 32'd8, 0, 0, 32'd8, 0, 0)); // ANDI
    tbl.push_back(mk(2'b01, 5'b00001, 0, 32'd8, 0, 0, 32'd8, 0, 0)); // ADDI
    tbl.push_back(mk(2'b01, 5'b00010, 0, 32'd8, 0, 0, 32'd8, 0, 0)); // LW
    tbl.push_back(mk(2'b01, 5'b00011, 0, 32'd8, 0, 0, 32'd8, 0, 0)); // SW
    tbl.push_back(mk(2'b01, 5'b00100, 0, 32'd8, 0, 0, 32'd8, 0, 0)); // BEQ
    tbl.push_back(mk(2'b10, 5'b00000, 0, 32'd8, 0, 0, 32'd8, 0, 0)); // J
    tbl.push_back(mk(2'b11, 5'b00001, 0, 32'd8, 0, 0, 32'd8, 0, 0)); // SLR
    tbl.push_back(mk(2'b10, 5'b00001, 0, 32'd8, 1, 0, 32'd9, 0, 0)); // JAL
    tbl.push_back(mk(2'b10, 5'b00001, 1, 32'd8, 1, 0, 32'd9, 0, 0)); // JAL + stop
    tbl.push_back(mk(2'b00, 5'b00011, 1, 32'd8, 0, 1, 32'd7, 0, 0)); // CMP + stop
    tbl.push_back(mk(2'b11, 5'b00000, 1, 32'd8, 0, 1, 32'd7, 0, 0)); // SLL + stop
    tbl.push_back(mk(2'b11, 5'b00010, 1, 32'd8, 0, 1, 32'd7, 0, 0)); // SLLV + stop
    tbl.push_back(mk(2'b11, 5'b00011, 1, 32'd8, 0, 1, 32'd7, 0, 0)); // SLRV + stop
    tbl.push_back(mk(2'b10, 5'b00001, 0, MAXV,  0, 0, MAXV,  1, 0)); // JAL at full
    tbl.push_back(mk(2'b10, 5'b00001, 0, 32'hFE, 1, 0, 32'hFF, 0, 0)); // JAL one below full
    tbl.push_back(mk(2'b01, 5'b00010, 1, BASE,  0, 0, BASE,  0, 1)); // pop at empty
    tbl.push_back(mk(2'b01, 5'b00010, 1, 32'd1, 0, 1, 32'd0, 0, 0)); // pop to empty
    tbl.push_back(mk(2'b10, 5'b00001, 1, BASE,  1, 0, 32'd1, 0, 0)); // JAL+stop at empty

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].it, tbl[i].op, tbl[i].sb, tbl[i].sp, 1'b0);
      #1;
      check_comb($sformatf("tbl%0d", i), tbl[i].e_push, tbl[i].e_pop,
                 tbl[i].e_nsp, tbl[i].e_ovf, tbl[i].e_unf);
    end

    // No commit over an overflow: flag must stay clear
    @(negedge clk);
    drive(2'b10, 5'b00001, 1'b0, MAXV, 1'b0);
    @(posedge clk); #1;
    check1("nocommit.stack_err", stack_err, 1'b0);

    // Committed underflow sets the sticky flag
    @(negedge clk);
    drive(2'b00, 5'b00000, 1'b1, BASE, 1'b1);
    #1;
    check1("seq.underflow", underflow, 1'b1);
    @(posedge clk); #1;
    check1("seq.stack_err_set", stack_err, 1'b1);

    // Flag holds after commit drops and inputs are legal again
    @(negedge clk);
    drive(2'b01, 5'b00001, 1'b0, 32'd8, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check1("seq.stack_err_hold", stack_err, 1'b1);

    // Asynchronous clear between edges; combinational path unaffected
    @(negedge clk);
    drive(2'b10, 5'b00001, 1'b0, 32'd8, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    check1("seq.async_clear", stack_err, 1'b0);
    check_comb("seq.in_reset", 1'b1, 1'b0, 32'd9, 1'b0, 1'b0);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check1("seq.after_release", stack_err, 1'b0);

    // Randomized stimulus against the depth model
    err_m = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [1:0]  it;
      logic [4:0]  op;
      logic        sb;
      logic [31:0] s;
      logic        c;
      @(negedge clk);
      case ($urandom_range(0, 5))
        0: s = BASE;
        1: s = MAXV;
        2: s = BASE + 32'd1;
        3: s = MAXV - 32'd1;
        default: s = 32'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 2) == 0) begin
        it = 2'b10;
        op = 5'b00001;
      end else begin
        it = 2'($urandom_range(0, 3));
        op = 5'($urandom_range(0, 31));
      end
      sb = 1'($urandom_range(0, 1));
      c  = ($urandom_range(0, 7) == 0);
      drive(it, op, sb, s, c);
      model(it, op, sb, s);
      #1;
      check_comb("rnd", m_push, m_pop, m_nsp, m_ovf, m_unf);
      if ($urandom_range(0, 24) == 0) begin
        reset_n = 1'b0;
        err_m   = 1'b0;
        #1;
        check1("rnd.async_clear", stack_err, 1'b0);
        reset_n = 1'b1;
      end
      if (c && (m_ovf || m_unf)) err_m = 1'b1;
      @(posedge clk); #1;
      check1("rnd.stack_err", stack_err, err_m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stack_control_unit.md
Name: stack_control_unit

Overview:
Stack-control decoder for the multi-cycle RISC processor.
- Inspects the current instruction's type, opcode and stop bit and decides whether the return-address stack is pushed (JAL) or popped (stop bit set, i.e. return after the instruction).
- Produces the next stack-pointer value from the processor's current SP and flags stack overflow/underflow.
- Push/pop/next_sp decode is combinational; only the sticky error flag is registered.

Parameters:
SP_W, 32, stack-pointer width in bits
SP_BASE, 32'h0000_0000, SP value when the stack is empty
SP_MAX, 32'h0000_00FF, highest legal SP value (stack full)

Ports:
clk  input  1  clock; only the sticky error register uses it
reset_n  input  1  asynchronous, active-low reset
instr_type  input  2  instruction class: 00 R, 01 I, 10 J, 11 S
opcode  input  5  opcode within the class
stop_bit  input  1  1 = pop the return address after this instruction
sp  input  SP_W  current stack pointer, owned by the datapath
commit  input  1  high in the cycle the datapath writes next_sp into SP
push  output  1  push the return address this instruction
pop  output  1  pop the return address this instruction
next_sp  output  SP_W  SP value after this instruction's stack operation
overflow  output  1  push requested while sp == SP_MAX
underflow  output  1  pop requested while sp == SP_BASE
stack_err  output  1  sticky: an overflow or underflow was committed

Behaviour:
- Stack convention: sp addresses the top occupied entry; empty when sp == SP_BASE.
- Push writes to address sp+1. Pop reads from address sp.
- push_req = (instr_type == 2'b10) and (opcode == 5'b00001), i.e. JAL only. All other opcodes and classes give push_req = 0.
- pop_req = stop_bit and not push_req.
  - Any class may carry the stop bit.
  - On JAL the stop bit is ignored: push has priority, and push and pop are never both 1.
- overflow = push_req and (sp == SP_MAX).
- underflow = pop_req and (sp == SP_BASE).
- push = push_req and not overflow. pop = pop_req and not underflow.
- next_sp:
  - push: sp + 1
  - pop: sp − 1
  - otherwise, including a suppressed push or pop: sp
- Arithmetic is SP_W-bit unsigned. Wrap-around cannot occur because the boundaries are blocked.
- All of the above is purely combinational with zero latency. Outputs follow the inputs in the same delta cycle, independent of clk and reset_n.
- stack_err register:
  - Async clear to 0 when reset_n = 0.
  - On rising clk with commit = 1 and (overflow or underflow), set to 1.
  - Otherwise holds its value. Cleared only by reset.
- Reset mid-operation clears stack_err immediately. Combinational outputs are unaffected.
- Unknown or reserved opcodes in any class decode as no push.
- Reset values: stack_err = 0. push, pop, next_sp, overflow and underflow are combinational and have no reset value.

Test Plan:
- sp = 8, stop_bit = 0; R AND/ADD/SUB, I ANDI/ADDI/LW/SW/BEQ, J J (opcode 00000), S SLR -> push = 0, pop = 0, next_sp = 8 in every case.
- sp = 8, J-type opcode 00001 (JAL), stop_bit = 0 -> push = 1, pop = 0, next_sp = 9. Repeat with stop_bit = 1 -> identical result (push priority).
- sp = 8, stop_bit = 1 with R CMP (00/00011), S SLL (11/00000), SLLV (11/00010) and SLRV (11/00011) -> push = 0, pop = 1, next_sp = 7 each.
- sp = SP_MAX (0xFF), JAL -> push = 0, overflow = 1, next_sp = 0xFF. sp = SP_BASE (0), stop_bit = 1 -> pop = 0, underflow = 1, next_sp = 0.
- Underflow case with commit = 1 across a clk edge -> stack_err = 1. It stays 1 after commit drops and the inputs return to legal values.
- Drive reset_n low between clk edges while stack_err = 1 -> stack_err = 0 immediately, with no clock edge needed.
